// File: rtl/alu_issue_stage.sv
// Decode/operand-read stage feeding an external ALU function unit, with write-back capture.
// Optional macro ALU_BYPASS_EN: forward fu_s to hazarding operands instead of stalling.
module alu_issue_stage #(
  parameter int NUM_REGS     = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [3:0]  fu_fs,
  input  logic [31:0] fu_s,
  input  logic [3:0]  fu_flags,
  output logic        ex_valid,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_flags,
  output logic        illegal
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [31:0] regs [NUM_REGS];
  logic [4:0]  ex_rd;
  logic        halted;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  f7;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  function automatic logic idx_ok(input logic [4:0] idx);
    return {27'b0, idx} < 32'(NUM_REGS);
  endfunction

  logic        is_op;
  logic        is_imm;
  logic        uses_rs2;
  logic        legal;
  logic [3:0]  dec_fs;
  logic [31:0] imm_b;

  always_comb begin
    is_op    = (opcode == OPC_OP);
    is_imm   = (opcode == OPC_OPIMM);
    uses_rs2 = is_op;
    legal    = 1'b0;
    dec_fs   = 4'b0000;
    imm_b    = 32'b0;
    if (is_op) begin
      dec_fs = {f3, f7[5]};
      legal  = (f7 == 7'b0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
    end else if (is_imm) begin
      if ((f3 == 3'b001) || (f3 == 3'b101)) begin
        // shift-immediate: upper bits carry the arithmetic-shift selector, not an immediate
        imm_b  = {27'b0, instr[24:20]};
        dec_fs = {f3, instr[30]};
        legal  = (f7 == 7'b0) || ((f7 == F7_ALT) && (f3 == 3'b101));
      end else begin
        imm_b  = {{20{instr[31]}}, instr[31:20]};
        dec_fs = {f3, 1'b0};
        legal  = 1'b1;
      end
    end
    legal = legal && idx_ok(rd) && idx_ok(rs1) && (!uses_rs2 || idx_ok(rs2));
  end

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  always_comb begin
    rs1_val = 32'b0;
    rs2_val = 32'b0;
    if ((rs1 != 5'd0) && idx_ok(rs1)) rs1_val = regs[rs1[RW-1:0]];
    if ((rs2 != 5'd0) && idx_ok(rs2)) rs2_val = regs[rs2[RW-1:0]];
  end

  logic        haz1;
  logic        haz2;
  logic        stall;
  logic [31:0] op_a;
  logic [31:0] op_b_reg;
  logic [31:0] op_b;

  always_comb begin
    haz1 = ex_valid && (ex_rd != 5'd0) && (is_op || is_imm) && (rs1 == ex_rd);
    haz2 = ex_valid && (ex_rd != 5'd0) && uses_rs2 && (rs2 == ex_rd);
`ifdef ALU_BYPASS_EN
    op_a     = haz1 ? fu_s : rs1_val;
    op_b_reg = haz2 ? fu_s : rs2_val;
    stall    = 1'b0;
`else
    op_a     = rs1_val;
    op_b_reg = rs2_val;
    stall    = haz1 || haz2;
`endif
    op_b        = is_op ? op_b_reg : imm_b;
    instr_ready = !halted && !stall;
  end

  logic accept;
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'b0;
    end else if (ex_valid && (ex_rd != 5'd0)) begin
      regs[ex_rd[RW-1:0]] <= fu_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_a     <= 32'b0;
      fu_b     <= 32'b0;
      fu_fs    <= 4'b0;
      ex_rd    <= 5'b0;
      ex_valid <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'b0;
      wb_data  <= 32'b0;
      wb_flags <= 4'b0;
      illegal  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd    <= ex_rd;
        wb_data  <= fu_s;
        wb_flags <= fu_flags;
      end
      ex_valid <= 1'b0;
      if (accept) begin
        if (legal) begin
          fu_a     <= op_a;
          fu_b     <= op_b;
          fu_fs    <= dec_fs;
          ex_rd    <= rd;
          ex_valid <= 1'b1;
        end else begin
          illegal <= 1'b1;
          if (ILLEGAL_HALT) halted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized run
// against an architectural (ISA-level) reference model.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'b0;

  // halting instance
  logic        instr_ready, ex_valid, wb_valid, illegal;
  logic [31:0] fu_a, fu_b, fu_s, wb_data;
  logic [3:0]  fu_fs, fu_flags, wb_flags;
  logic [4:0]  wb_rd;
  // drop-and-continue instance
  logic        ready0, ex_valid0, wb_valid0, illegal0;
  logic [31:0] fu_a0, fu_b0, fu_s0, wb_data0;
  logic [3:0]  fu_fs0, fu_flags0, wb_flags0;
  logic [4:0]  wb_rd0;

  function automatic logic [31:0] fu_calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fs);
    case (fs)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << b[4:0];
      4'b0100: return {31'b0, $signed(a) < $signed(b)};
      4'b0110: return {31'b0, a < b};
      4'b1000: return a ^ b;
      4'b1010: return a >> b[4:0];
      4'b1011: return $unsigned($signed(a) >>> b[4:0]);
      4'b1100: return a | b;
      4'b1110: return a & b;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [3:0] fu_flag(input logic [31:0] s);
    return {s == 32'b0, ^s, s[31], s[0]};
  endfunction

  assign fu_s      = fu_calc(fu_a, fu_b, fu_fs);
  assign fu_flags  = fu_flag(fu_s);
  assign fu_s0     = fu_calc(fu_a0, fu_b0, fu_fs0);
  assign fu_flags0 = fu_flag(fu_s0);

  alu_issue_stage #(.NUM_REGS(32), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs), .fu_s(fu_s),
    .fu_flags(fu_flags), .ex_valid(ex_valid), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_flags(wb_flags), .illegal(illegal));

  alu_issue_stage #(.NUM_REGS(32), .ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ready0),
    .instr(instr), .fu_a(fu_a0), .fu_b(fu_b0), .fu_fs(fu_fs0), .fu_s(fu_s0),
    .fu_flags(fu_flags0), .ex_valid(ex_valid0), .wb_valid(wb_valid0), .wb_rd(wb_rd0),
    .wb_data(wb_data0), .wb_flags(wb_flags0), .illegal(illegal0));

  int checks = 0;
  int errors = 0;

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Holds instr_valid until the halting instance accepts; returns just after the accept edge.
  task automatic send(input logic [31:0] w, output int stalls, output bit ok);
    logic r;
    instr = w;
    instr_valid = 1'b1;
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r = instr_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", instr_ready); end
    checks++; if ({ex_valid, wb_valid, illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ex_valid, wb_valid, illegal}); end
    checks++; if ({fu_a, fu_b, fu_fs} !== 68'b0) begin errors++; $display("FAIL reset_fu got %h exp 0", {fu_a, fu_b, fu_fs}); end
    checks++; if ({wb_rd, wb_data, wb_flags} !== 41'b0) begin errors++; $display("FAIL reset_wb got %h exp 0", {wb_rd, wb_data, wb_flags}); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    int st; bit ok;
    send(32'h00500093, st, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL addi_accept got %0b exp 1", ok); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL addi_ex_valid got %0b exp 1", ex_valid); end
    checks++; if (fu_a !== 32'd0) begin errors++; $display("FAIL addi_fu_a got %h exp 0", fu_a); end
    checks++; if (fu_b !== 32'd5) begin errors++; $display("FAIL addi_fu_b got %h exp 5", fu_b); end
    checks++; if (fu_fs !== 4'b0000) begin errors++; $display("FAIL addi_fu_fs got %b exp 0000", fu_fs); end
    @(posedge clk); #1;
    checks++; if ({wb_valid, wb_rd} !== {1'b1, 5'd1}) begin errors++; $display("FAIL addi_wb got v=%0b rd=%0d exp v=1 rd=1", wb_valid, wb_rd); end
    checks++; if (wb_data !== 32'd5) begin errors++; $display("FAIL addi_wb_data got %h exp 5", wb_data); end
    checks++; if (wb_flags !== fu_flag(32'd5)) begin errors++; $display("FAIL addi_wb_flags got %b exp %b", wb_flags, fu_flag(32'd5)); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL addi_ex_drop got %0b exp 0", ex_valid); end
  endtask

  task automatic test_back_to_back();
    int st; bit ok;
    do_reset();
    send(32'h00500093, st, ok);
    send(32'h00108133, st, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0b exp 1", ok); end
    checks++; if (st !== (BYP ? 0 : 1)) begin errors++; $display("FAIL b2b_stalls got %0d exp %0d", st, BYP ? 0 : 1); end
    checks++; if ({fu_a, fu_b} !== {32'd5, 32'd5}) begin errors++; $display("FAIL b2b_operands got a=%h b=%h exp 5 5", fu_a, fu_b); end
    @(posedge clk); #1;
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 32'd10}) begin errors++; $display("FAIL b2b_wb got v=%0b rd=%0d d=%h exp 1 2 a", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_imm();
    int st; bit ok;
    send(32'h4020D193, st, ok);
    checks++; if ({fu_a, fu_b} !== {32'd5, 32'd2}) begin errors++; $display("FAIL srai_operands got a=%h b=%h exp 5 2", fu_a, fu_b); end
    checks++; if (fu_fs !== 4'b1011) begin errors++; $display("FAIL srai_fs got %b exp 1011", fu_fs); end
    send(32'hFFF07013, st, ok);
    checks++; if (st !== 0) begin errors++; $display("FAIL andi_stalls got %0d exp 0", st); end
    checks++; if (fu_b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL andi_fu_b got %h exp ffffffff", fu_b); end
    checks++; if (fu_fs !== 4'b1110) begin errors++; $display("FAIL andi_fs got %b exp 1110", fu_fs); end
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, 32'd1}) begin errors++; $display("FAIL srai_wb got v=%0b rd=%0d d=%h exp 1 3 1", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_x0();
    int st; bit ok;
    send(32'h00700013, st, ok);
    send(32'h00000233, st, ok);
    checks++; if (st !== 0) begin errors++; $display("FAIL x0_stalls got %0d exp 0", st); end
    checks++; if ({fu_a, fu_b} !== 64'b0) begin errors++; $display("FAIL x0_operands got a=%h b=%h exp 0 0", fu_a, fu_b); end
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd0, 32'd7}) begin errors++; $display("FAIL x0_wb got v=%0b rd=%0d d=%h exp 1 0 7", wb_valid, wb_rd, wb_data); end
    @(posedge clk); #1;
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd4, 32'd0}) begin errors++; $display("FAIL x0_add_wb got v=%0b rd=%0d d=%h exp 1 4 0", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_illegal();
    int st; bit ok; int hi;
    do_reset();
    send(32'h02208033, st, ok);
    checks++; if ({illegal, ex_valid} !== 2'b10) begin errors++; $display("FAIL illegal_halt_state got ill=%0b ex=%0b exp 1 0", illegal, ex_valid); end
    checks++; if ({illegal0, ex_valid0} !== 2'b10) begin errors++; $display("FAIL illegal_drop_state got ill=%0b ex=%0b exp 1 0", illegal0, ex_valid0); end
    instr = 32'h00500093;
    instr_valid = 1'b1;
    @(negedge clk);
    checks++; if ({instr_ready, ready0} !== 2'b01) begin errors++; $display("FAIL illegal_ready got halt=%0b drop=%0b exp 0 1", instr_ready, ready0); end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++; if ({ex_valid0, fu_b0} !== {1'b1, 32'd5}) begin errors++; $display("FAIL illegal_drop_next got ex=%0b b=%h exp 1 5", ex_valid0, fu_b0); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL illegal_halt_ex got %0b exp 0", ex_valid); end
    // stray illegal into the non-halting copy is consumed without issuing
    instr = 32'h40209033;
    instr_valid = 1'b1;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (instr_ready !== 1'b0) hi++;
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL halt_hold got %0d ready cycles exp 0", hi); end
    checks++; if (ex_valid0 !== 1'b0) begin errors++; $display("FAIL illegal_f7_drop got %0b exp 0", ex_valid0); end
    do_reset();
    @(negedge clk);
    checks++; if ({instr_ready, illegal} !== 2'b10) begin errors++; $display("FAIL halt_release got rdy=%0b ill=%0b exp 1 0", instr_ready, illegal); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int st; bit ok;
    do_reset();
    send(32'h02208033, st, ok);
    instr = 32'h00500093;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++; if ({ex_valid0, illegal0, illegal} !== 3'b111) begin errors++; $display("FAIL arst_pre got %b exp 111", {ex_valid0, illegal0, illegal}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ex_valid0, wb_valid0, illegal0, illegal} !== 4'b0) begin errors++; $display("FAIL arst_flags got %b exp 0000", {ex_valid0, wb_valid0, illegal0, illegal}); end
    checks++; if ({fu_a0, fu_b0, fu_fs0} !== 68'b0) begin errors++; $display("FAIL arst_fu got %h exp 0", {fu_a0, fu_b0, fu_fs0}); end
    @(posedge clk); #1 rst_n = 1'b1;
    checks++; if (wb_valid0 !== 1'b0) begin errors++; $display("FAIL arst_no_wb got %0b exp 0", wb_valid0); end
    send(32'h00108133, st, ok);
    checks++; if ({ok, fu_a, fu_a0} !== {1'b1, 64'b0}) begin errors++; $display("FAIL arst_x1_clear got ok=%0b a=%h a0=%h exp 1 0 0", ok, fu_a, fu_a0); end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] rd, rs1, rs2, sh;
    logic [2:0] f3;
    logic [6:0] f7;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) begin
      f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'b0100000 : 7'b0;
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
    end
    if (f3 == 3'd1) return {7'b0, sh, rs1, f3, rd, 7'b0010011};
    if (f3 == 3'd5) return {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0, sh, rs1, f3, rd, 7'b0010011};
    return {12'($urandom_range(0, 4095)), rs1, f3, rd, 7'b0010011};
  endfunction

  // Architectural meaning of an RV32I OP/OP-IMM instruction.
  function automatic logic [31:0] isa_exec(input logic [31:0] w, input logic [31:0] a, input logic [31:0] r2);
    logic is_op;
    logic [31:0] b;
    is_op = (w[6:0] == 7'b0110011);
    if (is_op) b = r2;
    else if ((w[14:12] == 3'd1) || (w[14:12] == 3'd5)) b = {27'b0, w[24:20]};
    else b = {{20{w[31]}}, w[31:20]};
    case (w[14:12])
      3'd0: return (is_op && w[30]) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return w[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  task automatic test_random();
    logic [31:0] arch [32];
    exp_t q[$];
    exp_t e;
    bit prev_acc, acc, haz, exp_rdy;
    logic [4:0] prev_rd, rd, rs1, rs2;
    logic [31:0] res;
    do_reset();
    for (int i = 0; i < 32; i++) arch[i] = 32'b0;
    prev_acc = 1'b0;
    prev_rd = 5'd0;
    for (int n = 0; n < 404; n++) begin
      instr = gen_instr();
      instr_valid = (n < 400) && ($urandom_range(0, 3) != 0);
      rd  = instr[11:7];
      rs1 = instr[19:15];
      rs2 = instr[24:20];
      @(negedge clk);
      haz = prev_acc && (prev_rd != 5'd0) &&
            ((rs1 == prev_rd) || ((instr[6:0] == 7'b0110011) && (rs2 == prev_rd)));
      exp_rdy = BYP ? 1'b1 : !haz;
      checks++; if (instr_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready n=%0d got %0b exp %0b", n, instr_ready, exp_rdy); end
      if (q.size() > 0 && q[0].due == n) begin
        e = q.pop_front();
        checks++;
        if ({wb_valid, wb_rd, wb_data, wb_flags} !== {1'b1, e.rd, e.data, fu_flag(e.data)}) begin
          errors++;
          $display("FAIL rnd_wb n=%0d got v=%0b rd=%0d d=%h f=%b exp v=1 rd=%0d d=%h f=%b",
                   n, wb_valid, wb_rd, wb_data, wb_flags, e.rd, e.data, fu_flag(e.data));
        end
      end else begin
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rnd_wb_idle n=%0d got %0b exp 0", n, wb_valid); end
      end
      acc = instr_valid && instr_ready;
      if (acc) begin
        res = isa_exec(instr, arch[rs1], arch[rs2]);
        if (rd != 5'd0) arch[rd] = res;
        q.push_back('{rd: rd, data: res, due: n + 2});
      end
      prev_acc = acc;
      prev_rd = rd;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_imm();
    test_x0();
    test_illegal();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-read stage directly upstream of the function unit (FU) that consumes A, B and FS and returns result S and ZCNVFlags.
- Accepts RV32I OP and OP-IMM instructions over a valid/ready handshake, reads a register file, and drives registered A/B/FS into the FU.
- Captures the FU result one cycle later, writes it back to the register file, and publishes it on a registered write-back port.

Parameters:
- NUM_REGS, 32, architectural register count: 32, or 16 for RV32E. Any rs1/rs2/rd index >= NUM_REGS is illegal.
- ILLEGAL_HALT, 1, 1: stall permanently after an illegal instruction; 0: drop it and continue.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  stage can accept; transfer occurs when valid&&ready at a clock edge
- instr  in  32  RV32I instruction word
- fu_a  out  32  FU operand A, registered
- fu_b  out  32  FU operand B, registered
- fu_fs  out  4  FU function select, registered
- fu_s  in  32  FU result, combinational from fu_a/fu_b/fu_fs
- fu_flags  in  4  FU ZCNV flags
- ex_valid  out  1  fu_a/fu_b/fu_fs hold a live instruction this cycle
- wb_valid  out  1  one-cycle pulse, write-back occurred
- wb_rd  out  5  destination register of the write-back
- wb_data  out  32  written value
- wb_flags  out  4  flags captured with the write-back
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (async, rst_n=0):
  - fu_a, fu_b, fu_fs, ex_valid, wb_valid, wb_rd, wb_data, wb_flags, illegal and all registers clear to 0 immediately.
  - Any in-flight instruction is discarded.
  - instr_ready=1 in the first cycle after release.
- Decode, OP (opcode 0110011):
  - fs={funct3,funct7[5]}.
  - Legal when funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
  - A=x[rs1], B=x[rs2].
- Decode, OP-IMM (opcode 0010011):
  - funct3 in {001,101}: B=zero-extended instr[24:20]; fs={funct3,instr[30]}. instr[31:25] must be 0000000, or 0100000 only for 101.
  - Other funct3: B=sign-extended instr[31:20]; fs={funct3,0}.
  - A=x[rs1].
- Resulting encodings: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Register file: x0 always reads 0, and writes to x0 are discarded. wb_valid still pulses with wb_rd=0.
- Pipeline:
  - Edge 1, accept: load fu_a/fu_b/fu_fs and the internal ex_rd; ex_valid=1.
  - Next cycle: the FU computes.
  - Edge 2: x[ex_rd]<=fu_s; wb_valid=1, wb_rd=ex_rd, wb_data=fu_s, wb_flags=fu_flags.
  - Latency accept->wb_valid = 2 edges. Throughput 1/cycle.
  - ex_valid drops when no accept occurs; fu_a/fu_b/fu_fs then hold their last values.
- RAW hazard: an accepted instruction reads rs equal to ex_rd while ex_valid, with ex_rd!=0. Resolution is defined by ALU_BYPASS_EN.
- Write-back and new accept on the same edge: the register-file write and the operand load both complete; the operand source is the bypass or the stall rule.
- Illegal instruction (bad opcode, funct7, or register index) on accept:
  - illegal<=1 (sticky until reset); no ex_valid is issued.
  - ILLEGAL_HALT=1: instr_ready=0 from the next cycle until reset.
  - ILLEGAL_HALT=0: the instruction is consumed and dropped.
  - An instruction already in EX still completes write-back.
- instr_ready is combinational from halt state, hazard state, and instr. It does not depend on instr_valid.

Optional Feature:
- Macro ALU_BYPASS_EN.
- Defined:
  - Hazarding operands take fu_s combinationally. No stall; instr_ready=1 unless halted.
- Undefined:
  - instr_ready=0 while a hazard exists, which inserts one bubble (ex_valid=0 for one cycle).
  - The instruction is accepted the following cycle and reads the register file, which was written at that edge.

Test Plan:
- Reset, then accept 0x00500093 (ADDI x1,x0,5) -> next cycle ex_valid=1, fu_a=0, fu_b=5, fu_fs=0000; following cycle wb_valid=1, wb_rd=1, wb_data=fu_s.
- Back-to-back 0x00500093 then 0x00108133 (ADD x2,x1,x1), FU modelled as adder -> bypass: no bubble, fu_a=fu_b=5, wb x2=10; no bypass: instr_ready=0 for exactly 1 cycle, same final x2=10.
- 0x4020D193 (SRAI x3,x1,2) -> fu_b=2, fu_fs=1011; 0x00000013 variant with funct3=111 and imm=0xFFF -> fu_b=0xFFFFFFFF, fu_fs=1110.
- 0x02208033 (MUL, funct7=0000001) -> illegal=1, ex_valid stays 0; ILLEGAL_HALT=1: instr_ready=0 until rst_n pulse; ILLEGAL_HALT=0: instr_ready=1 and the next ADDI executes.
- 0x00700013 (ADDI x0,x0,7) then ADD x4,x0,x0 -> wb_rd=0 pulse; second op fu_a=fu_b=0, no hazard stall.
- rst_n low asynchronously mid-cycle with ex_valid=1 -> ex_valid, wb_valid, fu_* and illegal clear before the next edge; no write-back occurs.
